semaforo_pedestre_param: RTL

- Parametrised successor to the team's single-crossing pedestrian light controller, for one vehicle approach and one pedestrian crosswalk.
- All phase durations are parameters counted in ticks of an external time-base strobe.
- Adds a minimum vehicle green, latched pedestrian requests with a wait indicator, all-red clearance phases and a flashing pedestrian-clearance phase.
- Sits between the button/tick infrastructure and the lamp drivers.

---
 rtl/semaforo_pkg.sv | 29 ++
 rtl/semaforo_timer.sv | 51 +++++
 rtl/semaforo_pedestre_param.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the parametrised pedestrian crossing
// controller (semaforo_pedestre_param).
//
// Contents:
//   estado_t    - the six controller states with fixed 3-bit encodings; the
//                 encoding is exported on the debug port 'estado'.
//   DEF_*       - default phase durations in time-base ticks.
//
// Optional build macro used by the files that import this package:
//   PED_COUNTDOWN_EN - adds the pedestrian countdown output.
package semaforo_pkg;

    typedef enum logic [2:0] {
        VEIC_VERDE  = 3'd0,
        AMARELO     = 3'd1,
        VERM_TOTAL1 = 3'd2,
        PED_VERDE   = 3'd3,
        PED_PISCA   = 3'd4,
        VERM_TOTAL2 = 3'd5
    } estado_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_T_MIN_GREEN = 6;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALL_RED   = 1;
    localparam int DEF_T_PED_WALK  = 4;
    localparam int DEF_T_PED_CLEAR = 3;

endpackage

// File: rtl/semaforo_timer.sv
// Phase timer for the pedestrian crossing controller.
//
// Counts ticks spent in the current phase. A synchronous clear (asserted on
// every state change) has priority over counting. With i_sat high the count
// stops at i_limit-1 instead of wrapping, so the vehicle green can wait
// indefinitely for a request.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset (count -> 0)
//   i_tick   in   time-base strobe; the count only moves when high
//   i_clr    in   synchronous clear
//   i_sat    in   hold at i_limit-1 instead of advancing
//   i_limit  in   phase length in ticks
//   o_done   out  count == i_limit-1 (last tick of the phase)
//   o_count  out  current count; only present with PED_COUNTDOWN_EN
module semaforo_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clr,
    input  logic             i_sat,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] o_count
`endif
);

    logic [CNT_W-1:0] r_cnt;

    assign o_done = (r_cnt == (i_limit - CNT_W'(1)));

`ifdef PED_COUNTDOWN_EN
    assign o_count = r_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick && !(i_sat && o_done)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/semaforo_pedestre_param.sv
// Single-approach vehicle light with one pedestrian crosswalk.
//
// Vehicle green lasts at least T_MIN_GREEN ticks and is only left when a
// pedestrian request is latched. A request then runs
// AMARELO -> VERM_TOTAL1 -> PED_VERDE -> PED_PISCA -> VERM_TOTAL2 -> VEIC_VERDE,
// each phase exactly T_* ticks of the external 'tick' strobe.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-low reset
//   tick            in   one-cycle time-base strobe
//   botao_pedestre  in   pedestrian button (already synchronised, level)
//   Q1/Q2/Q3        out  vehicle red / yellow / green
//   Q4/Q5           out  pedestrian red / green
//   req_pending     out  "wait" lamp, high while a request is latched
//   estado          out  current state encoding (debug)
//   ped_countdown   out  remaining pedestrian ticks; only with PED_COUNTDOWN_EN
//
// Optional build macro: PED_COUNTDOWN_EN.
module semaforo_pedestre_param
    import semaforo_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int T_PED_WALK  = DEF_T_PED_WALK,
    parameter int T_PED_CLEAR = DEF_T_PED_CLEAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       botao_pedestre,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       Q4,
    output logic       Q5,
    output logic       req_pending,
    output logic [2:0] estado
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] ped_countdown
`endif
);

    estado_t          r_state;
    estado_t          w_next;
    logic [CNT_W-1:0] w_limit;
    logic             w_done;
    logic             w_state_chg;
    logic             r_req;
    logic             r_botao_q;
    logic             w_btn_rise;
    logic             r_flash;
`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] w_count;
`endif

    assign w_state_chg = (w_next != r_state);
    assign w_btn_rise  = botao_pedestre & ~r_botao_q;

    semaforo_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_tick  (tick),
        .i_clr   (w_state_chg),
        .i_sat   (r_state == VEIC_VERDE),
        .i_limit (w_limit),
        .o_done  (w_done)
`ifdef PED_COUNTDOWN_EN
        ,
        .o_count (w_count)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= VEIC_VERDE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-phase length. Every exit needs a tick on the last
    // count of the phase, so state changes never happen with tick low.
    always_comb begin
        w_next  = r_state;
        w_limit = CNT_W'(T_MIN_GREEN);
        case (r_state)
            VEIC_VERDE: begin
                w_limit = CNT_W'(T_MIN_GREEN);
                if (tick && w_done && r_req) w_next = AMARELO;
            end
            AMARELO: begin
                w_limit = CNT_W'(T_YELLOW);
                if (tick && w_done) w_next = VERM_TOTAL1;
            end
            VERM_TOTAL1: begin
                w_limit = CNT_W'(T_ALL_RED);
                if (tick && w_done) w_next = PED_VERDE;
            end
            PED_VERDE: begin
                w_limit = CNT_W'(T_PED_WALK);
                if (tick && w_done) w_next = PED_PISCA;
            end
            PED_PISCA: begin
                w_limit = CNT_W'(T_PED_CLEAR);
                if (tick && w_done) w_next = VERM_TOTAL2;
            end
            VERM_TOTAL2: begin
                w_limit = CNT_W'(T_ALL_RED);
                if (tick && w_done) w_next = VEIC_VERDE;
            end
            default: w_next = VEIC_VERDE;
        endcase
    end

    // Request latch runs every cycle, independent of tick. Entry into
    // PED_VERDE serves the request and beats a simultaneous new edge; edges
    // while pedestrians already walk are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_botao_q <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            r_botao_q <= botao_pedestre;
            if (w_next == PED_VERDE && r_state != PED_VERDE) begin
                r_req <= 1'b0;
            end else if (w_btn_rise && r_state != PED_VERDE) begin
                r_req <= 1'b1;
            end
        end
    end

    // Pedestrian red flashes during clearance, starting lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flash <= 1'b1;
        end else if (w_next == PED_PISCA && r_state != PED_PISCA) begin
            r_flash <= 1'b1;
        end else if (r_state == PED_PISCA && tick) begin
            r_flash <= ~r_flash;
        end
    end

    always_comb begin
        Q1 = 1'b0;
        Q2 = 1'b0;
        Q3 = 1'b0;
        Q4 = 1'b0;
        Q5 = 1'b0;
        case (r_state)
            VEIC_VERDE:  begin Q3 = 1'b1; Q4 = 1'b1;    end
            AMARELO:     begin Q2 = 1'b1; Q4 = 1'b1;    end
            VERM_TOTAL1: begin Q1 = 1'b1; Q4 = 1'b1;    end
            PED_VERDE:   begin Q1 = 1'b1; Q5 = 1'b1;    end
            PED_PISCA:   begin Q1 = 1'b1; Q4 = r_flash; end
            VERM_TOTAL2: begin Q1 = 1'b1; Q4 = 1'b1;    end
            default:     begin Q3 = 1'b1; Q4 = 1'b1;    end
        endcase
    end

    assign req_pending = r_req;
    assign estado      = r_state;

`ifdef PED_COUNTDOWN_EN
    // Ticks left until pedestrians lose right of way.
    always_comb begin
        ped_countdown = '0;
        if (r_state == PED_VERDE) begin
            ped_countdown = CNT_W'(T_PED_WALK + T_PED_CLEAR) - w_count;
        end else if (r_state == PED_PISCA) begin
            ped_countdown = CNT_W'(T_PED_CLEAR) - w_count;
        end
    end
`endif

endmodule
